audio_clock_nco: RTL

Parametrised numerically-controlled oscillator for the audio subsystem. It generates the audio sample clock from the system clock by phase accumulation. The increment is runtime-programmable through a valid/ready handshake and takes effect glitch-free at phase wrap. The block also emits a one-cycle sample strobe and a divided frame strobe, which the synthesizer voices and the codec interface consume.

---
 rtl/audio_clock_nco.sv | 105 ++++++++++
 1 files changed

// File: rtl/audio_clock_nco.sv
`default_nettype none
// ============================================================================
// Module      : audio_clock_nco
// Description : Phase-accumulating NCO producing the audio sample clock, a
//               one-cycle sample strobe and a divided frame strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module audio_clock_nco #(
    parameter int          ACC_WIDTH   = 32,
    parameter int unsigned DEFAULT_INC = 4123168,
    parameter int          DIV_WIDTH   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [ACC_WIDTH-1:0] inc_in,
    input  logic                 inc_valid,
    output logic                 inc_ready,
    input  logic [DIV_WIDTH-1:0] frame_div,
    output logic [ACC_WIDTH-1:0] phase,
    output logic                 audio_clock,
    output logic                 sample_tick,
    output logic                 frame_tick,
    output logic                 inc_pending
);

    localparam int                   c_msb         = ACC_WIDTH - 1;
    localparam logic [ACC_WIDTH-1:0] c_default_inc = ACC_WIDTH'(DEFAULT_INC);
    localparam logic [DIV_WIDTH-1:0] c_div_one     = DIV_WIDTH'(1);

    logic [ACC_WIDTH-1:0] r_phase;
    logic [ACC_WIDTH-1:0] r_active_inc;
    logic [ACC_WIDTH-1:0] r_pending_inc;
    logic                 r_inc_pending;
    logic                 r_sample_tick;
    logic                 r_frame_tick;
    logic [DIV_WIDTH-1:0] r_frame_cnt;

    logic [ACC_WIDTH:0]   w_sum;
    logic                 w_wrap;
    logic                 w_rise;
    logic                 w_accept;
    logic                 w_apply;
    logic                 w_frame_hit;

    // One extra bit so the carry out of the accumulator is the wrap flag.
    assign w_sum    = {1'b0, r_phase} + {1'b0, r_active_inc};
    assign w_wrap   = enable & w_sum[ACC_WIDTH];
    assign w_rise   = enable & ~r_phase[c_msb] & w_sum[c_msb];
    assign w_accept = inc_valid & ~r_inc_pending;

    // A zero increment never wraps, so it would otherwise lock out any update.
    assign w_apply  = r_inc_pending & (w_wrap | (r_active_inc == '0));

    // Compare with >= so shrinking frame_div at runtime still terminates.
    assign w_frame_hit = (frame_div <= c_div_one) ||
                         (r_frame_cnt >= (frame_div - c_div_one));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_phase       <= '0;
            r_active_inc  <= c_default_inc;
            r_pending_inc <= '0;
            r_inc_pending <= 1'b0;
        end else begin
            if (enable) begin
                r_phase <= w_sum[ACC_WIDTH-1:0];
            end
            if (w_apply) begin
                r_active_inc  <= r_pending_inc;
                r_inc_pending <= 1'b0;
            end else if (w_accept) begin
                r_pending_inc <= inc_in;
                r_inc_pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sample_tick <= 1'b0;
            r_frame_tick  <= 1'b0;
            r_frame_cnt   <= '0;
        end else begin
            r_sample_tick <= w_rise;
            r_frame_tick  <= w_rise & w_frame_hit;
            if (w_rise) begin
                if (w_frame_hit) begin
                    r_frame_cnt <= '0;
                end else begin
                    r_frame_cnt <= r_frame_cnt + c_div_one;
                end
            end
        end
    end

    assign phase       = r_phase;
    assign audio_clock = r_phase[c_msb];
    assign sample_tick = r_sample_tick;
    assign frame_tick  = r_frame_tick;
    assign inc_pending = r_inc_pending;
    assign inc_ready   = ~r_inc_pending;

endmodule
`default_nettype wire
